// File: rtl/dwt_row_aligner.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dwt_row_aligner
//
// Output framing stage after the row lifting chain of the 2-D 9/7 DWT.
// For every line, drops the first SkipCount pipeline warm-up beats and
// re-attaches the line's start-of-frame marker to the first beat it emits.
// A run-time bypass passes whole lines untouched. Line length is checked
// and violations raise sticky error flags.
//
// Optional feature macro: DWT_ROW_ALIGN_STATS_EN (adds statistics outputs).
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous reset, active low
//   cfg_bypass_i    1 = pass every beat of the next line, no skipping
//   s_ready_o       upstream ready (registered)
//   s_valid_i       upstream valid
//   s_sof_i         start of frame, on a line's first beat
//   s_eol_i         end of line, on a line's last beat
//   s_data_i        Channels lanes of {high, low}, lane k at [k*2*DataWidth +: 2*DataWidth]
//   m_ready_i       downstream ready
//   m_valid_o       downstream valid
//   m_sof_o         start of frame, on the first emitted beat of a line
//   m_eol_o         end of line
//   m_data_o        same packing as s_data_i
//   err_o           sticky flags: [0] short line, [1] long line
//   err_clr_i       synchronous clear of err_o (and statistics)
//   stat_lines_o    (DWT_ROW_ALIGN_STATS_EN) lines emitted, wrapping
//   stat_skipped_o  (DWT_ROW_ALIGN_STATS_EN) beats consumed in SKIP/DROP, saturating
// ---------------------------------------------------------------------------
module dwt_row_aligner #(
    parameter int DataWidth       = 16,
    parameter int Channels        = 1,
    parameter int SkipCount       = 4,
    parameter int MaximumSideSize = 512
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cfg_bypass_i,
    output logic                            s_ready_o,
    input  logic                            s_valid_i,
    input  logic                            s_sof_i,
    input  logic                            s_eol_i,
    input  logic [Channels*2*DataWidth-1:0] s_data_i,
    input  logic                            m_ready_i,
    output logic                            m_valid_o,
    output logic                            m_sof_o,
    output logic                            m_eol_o,
    output logic [Channels*2*DataWidth-1:0] m_data_o,
    output logic [1:0]                      err_o,
    input  logic                            err_clr_i
`ifdef DWT_ROW_ALIGN_STATS_EN
    ,
    output logic [15:0]                     stat_lines_o,
    output logic [15:0]                     stat_skipped_o
`endif
);

    localparam int BusW     = Channels * 2 * DataWidth;
    localparam int MaxBeats = MaximumSideSize / 2;
    localparam int BeatW    = $clog2(MaxBeats + 1);

    localparam logic [BeatW-1:0] LastBeat  = BeatW'(MaxBeats - 1);
    localparam logic [3:0]       SkipDepth = 4'(SkipCount);

    typedef enum logic [1:0] {
        SKIP = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        skip_cnt_q, skip_cnt_d;
    logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
    logic              pending_sof_q, pending_sof_d;
    logic              bypass_q, bypass_d;
    logic [1:0]        err_d;

    logic              accept;
    logic              pop;
    logic              bypass_eff;
    logic              line_beat;
    logic              skip_beat;
    logic              push;
    logic              push_sof;
    logic              push_eol;
    logic [1:0]        occ_d;
    logic              ready_d;

    // Second (skid) entry of the output buffer; the first entry is the
    // output register itself.
    logic              skid_valid_q;
    logic [BusW-1:0]   skid_data_q;
    logic              skid_sof_q;
    logic              skid_eol_q;

    assign accept = s_valid_i && s_ready_o;
    assign pop    = m_valid_o && m_ready_i;

    // The bypass setting is only looked at while idle between lines, so a
    // change in the middle of a line waits for the next one.
    assign bypass_eff = (state_q == SKIP && skip_cnt_q == 4'd0) ? cfg_bypass_i : bypass_q;

    // Next-state logic: decides per accepted beat whether it is skipped,
    // forwarded into the buffer, or dropped, and tracks line framing.
    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        pending_sof_d = pending_sof_q;
        bypass_d      = bypass_q;
        err_d         = err_clr_i ? 2'b00 : err_o;
        line_beat     = 1'b0;
        skip_beat     = 1'b0;
        push          = 1'b0;
        push_sof      = 1'b0;
        push_eol      = 1'b0;

        if (state_q == SKIP && skip_cnt_q == 4'd0) begin
            bypass_d = cfg_bypass_i;
        end

        case (state_q)
            SKIP: begin
                if (accept) begin
                    if (bypass_eff) begin
                        // Zero skip depth: the beat is handled as a pass beat.
                        line_beat = 1'b1;
                    end else begin
                        skip_beat = 1'b1;
                        if (s_eol_i) begin
                            // Line ended before warm-up finished: nothing emitted.
                            err_d[0]      = 1'b1;
                            pending_sof_d = 1'b0;
                            skip_cnt_d    = 4'd0;
                        end else begin
                            if (s_sof_i) begin
                                pending_sof_d = 1'b1;
                            end
                            skip_cnt_d = skip_cnt_q + 4'd1;
                            if (skip_cnt_q + 4'd1 == SkipDepth) begin
                                state_d = PASS;
                            end
                        end
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    line_beat = 1'b1;
                end
            end
            DROP: begin
                if (accept) begin
                    skip_beat = 1'b1;
                    if (s_eol_i) begin
                        state_d    = SKIP;
                        skip_cnt_d = 4'd0;
                        beat_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SKIP;
            end
        endcase

        if (line_beat) begin
            push          = 1'b1;
            push_sof      = (beat_cnt_q == '0) && (pending_sof_q || s_sof_i);
            pending_sof_d = 1'b0;
            if (s_eol_i) begin
                push_eol   = 1'b1;
                beat_cnt_d = '0;
                skip_cnt_d = 4'd0;
                state_d    = SKIP;
            end else if (beat_cnt_q == LastBeat) begin
                // Line too long: close it here and discard the rest.
                push_eol   = 1'b1;
                err_d[1]   = 1'b1;
                beat_cnt_d = '0;
                skip_cnt_d = 4'd0;
                state_d    = DROP;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                state_d    = PASS;
            end
        end

        // Buffer occupancy after this cycle; ready is registered from it.
        // DROP never writes the buffer so it keeps accepting regardless.
        occ_d   = {1'b0, m_valid_o} + {1'b0, skid_valid_q} + {1'b0, push} - {1'b0, pop};
        ready_d = (state_d == DROP) || (occ_d != 2'd2);
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= SKIP;
            skip_cnt_q    <= 4'd0;
            beat_cnt_q    <= '0;
            pending_sof_q <= 1'b0;
            bypass_q      <= 1'b0;
            err_o         <= 2'b00;
            s_ready_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            pending_sof_q <= pending_sof_d;
            bypass_q      <= bypass_d;
            err_o         <= err_d;
            s_ready_o     <= ready_d;
        end
    end

    // Two-entry skid buffer: the output register refills from the skid
    // entry first so beat order is preserved; a new beat lands in the skid
    // entry only while the output is stalled or the skid entry is draining.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid_o    <= 1'b0;
            m_data_o     <= '0;
            m_sof_o      <= 1'b0;
            m_eol_o      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sof_q   <= 1'b0;
            skid_eol_q   <= 1'b0;
        end else if (!m_valid_o || m_ready_i) begin
            if (skid_valid_q) begin
                m_valid_o <= 1'b1;
                m_data_o  <= skid_data_q;
                m_sof_o   <= skid_sof_q;
                m_eol_o   <= skid_eol_q;
                if (push) begin
                    skid_data_q <= s_data_i;
                    skid_sof_q  <= push_sof;
                    skid_eol_q  <= push_eol;
                end else begin
                    skid_valid_q <= 1'b0;
                end
            end else if (push) begin
                m_valid_o <= 1'b1;
                m_data_o  <= s_data_i;
                m_sof_o   <= push_sof;
                m_eol_o   <= push_eol;
            end else begin
                m_valid_o <= 1'b0;
            end
        end else if (push) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= s_data_i;
            skid_sof_q   <= push_sof;
            skid_eol_q   <= push_eol;
        end
    end

`ifdef DWT_ROW_ALIGN_STATS_EN
    // Statistics: lines counted when their eol beat leaves the block;
    // the skipped-beat count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_lines_o   <= 16'd0;
            stat_skipped_o <= 16'd0;
        end else if (err_clr_i) begin
            stat_lines_o   <= 16'd0;
            stat_skipped_o <= 16'd0;
        end else begin
            if (pop && m_eol_o) begin
                stat_lines_o <= stat_lines_o + 16'd1;
            end
            if (skip_beat && stat_skipped_o != 16'hFFFF) begin
                stat_skipped_o <= stat_skipped_o + 16'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_dwt_row_aligner.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_dwt_row_aligner
//
// Scoreboard bench for dwt_row_aligner (3 lanes, SkipCount 4, 16-sample
// lines). The driver pushes the hand-derived expected beat for every beat
// that should come out; an independent monitor pops and compares each beat
// the DUT emits, and checks held outputs during downstream stalls.
// ---------------------------------------------------------------------------
module tb_dwt_row_aligner;

    localparam int DataWidth = 16;
    localparam int Channels  = 3;
    localparam int SkipCount = 4;
    localparam int MaxSide   = 16;
    localparam int BusW      = Channels * 2 * DataWidth;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            cfg_bypass_i;
    logic            s_ready_o;
    logic            s_valid_i;
    logic            s_sof_i;
    logic            s_eol_i;
    logic [BusW-1:0] s_data_i;
    logic            m_ready_i;
    logic            m_valid_o;
    logic            m_sof_o;
    logic            m_eol_o;
    logic [BusW-1:0] m_data_o;
    logic [1:0]      err_o;
    logic            err_clr_i;
`ifdef DWT_ROW_ALIGN_STATS_EN
    logic [15:0]     stat_lines_o;
    logic [15:0]     stat_skipped_o;
`endif

    typedef struct packed {
        logic [BusW-1:0] data;
        logic            sof;
        logic            eol;
    } beat_t;

    beat_t expQ[$];
    beat_t monBeat;
    int    total = 0;
    int    bad = 0;
    int    cycle = 0;
    int    readyMode = 0;
    int    firstAcc;
    int    lastAcc;

    dwt_row_aligner #(
        .DataWidth      (DataWidth),
        .Channels       (Channels),
        .SkipCount      (SkipCount),
        .MaximumSideSize(MaxSide)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cfg_bypass_i  (cfg_bypass_i),
        .s_ready_o     (s_ready_o),
        .s_valid_i     (s_valid_i),
        .s_sof_i       (s_sof_i),
        .s_eol_i       (s_eol_i),
        .s_data_i      (s_data_i),
        .m_ready_i     (m_ready_i),
        .m_valid_o     (m_valid_o),
        .m_sof_o       (m_sof_o),
        .m_eol_o       (m_eol_o),
        .m_data_o      (m_data_o),
        .err_o         (err_o),
        .err_clr_i     (err_clr_i)
`ifdef DWT_ROW_ALIGN_STATS_EN
        ,
        .stat_lines_o  (stat_lines_o),
        .stat_skipped_o(stat_skipped_o)
`endif
    );

    // Free-running clock and cycle counter.
    always #5 clk_i = ~clk_i;

    initial begin
        forever begin
            @(posedge clk_i);
            cycle = cycle + 1;
        end
    end

    // Beat payload: lane k low = 0x5000 + k*0x100 + idx, high = 0xA000 + k*0x100 + idx.
    function automatic logic [BusW-1:0] beatData(input int idx);
        logic [BusW-1:0] d;
        d = '0;
        for (int k = 0; k < Channels; k++) begin
            d[k*2*DataWidth +: DataWidth]             = 16'(32'h5000 + k * 256 + idx);
            d[k*2*DataWidth + DataWidth +: DataWidth] = 16'(32'hA000 + k * 256 + idx);
        end
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready pattern: 0 = always high, 1 = toggling, 2 = held low.
    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (readyMode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = ~m_ready_i;
                default: m_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: compares every emitted beat against the scoreboard and, while
    // stalled, checks that the presented beat is still the expected head.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && m_valid_o) begin
                if (expQ.size() == 0) begin
                    total = total + 1;
                    bad = bad + 1;
                    $display("[TB] FAIL unexpected_beat: got sof=%0b eol=%0b data=%0h, expected no beat",
                             m_sof_o, m_eol_o, m_data_o);
                end else if (m_ready_i) begin
                    monBeat = expQ.pop_front();
                    checkOutput("beat", {m_sof_o, m_eol_o, m_data_o}, {monBeat.sof, monBeat.eol, monBeat.data});
                end else begin
                    checkOutput("stall_hold", {m_sof_o, m_eol_o, m_data_o}, {expQ[0].sof, expQ[0].eol, expQ[0].data});
                end
            end
        end
    end

    task automatic alignDrive();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one beat (called just after a rising edge) and records the
    // expected output beat when the transfer is certain.
    task automatic applyStimulus(input int idx, input bit sof, input bit eol, input bit emit,
                                 input bit esof, input bit eeol, output int accCycle);
        int waitCnt;
        beat_t b;
        waitCnt = 0;
        s_valid_i = 1'b1;
        s_sof_i   = sof;
        s_eol_i   = eol;
        s_data_i  = beatData(idx);
        do begin
            @(negedge clk_i);
            waitCnt = waitCnt + 1;
        end while (!s_ready_o && waitCnt < 200);
        if (!s_ready_o) begin
            total = total + 1;
            bad = bad + 1;
            $display("[TB] FAIL accept_timeout: beat %0d not accepted, s_ready_o=%0b required 1", idx, s_ready_o);
        end else if (emit) begin
            b.data = beatData(idx);
            b.sof  = esof;
            b.eol  = eeol;
            expQ.push_back(b);
        end
        accCycle = cycle;
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
    endtask

    // Sends nSend beats of a lineLen-beat line; beats firstEmit..lastEmit
    // are expected out, sof on firstEmit and eol on lastEmit.
    task automatic sendLine(input int lineLen, input int nSend, input int firstEmit, input int lastEmit,
                            input int toggleAt, input int latencyBeat);
        int acc;
        for (int i = 0; i < nSend; i++) begin
            if (i == toggleAt) begin
                cfg_bypass_i = ~cfg_bypass_i;
            end
            applyStimulus(i, i == 0, i == lineLen - 1, (i >= firstEmit) && (i <= lastEmit),
                          i == firstEmit, i == lastEmit, acc);
            if (i == 0) firstAcc = acc;
            lastAcc = acc;
            if (i == latencyBeat) begin
                @(negedge clk_i);
                checkOutput("latency_valid", m_valid_o, 1'b1);
                checkOutput("latency_data", m_data_o, beatData(i));
                alignDrive();
            end
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || m_valid_o) && n < 300) begin
            @(negedge clk_i);
            n = n + 1;
        end
        checkOutput({name, "_pending"}, expQ.size(), 0);
    endtask

    task automatic clearErrors();
        alignDrive();
        err_clr_i = 1'b1;
        alignDrive();
        err_clr_i = 1'b0;
        @(negedge clk_i);
        checkOutput("err_cleared", err_o, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        cfg_bypass_i = 1'b0;
        s_valid_i    = 1'b0;
        s_sof_i      = 1'b0;
        s_eol_i      = 1'b0;
        s_data_i     = '0;
        err_clr_i    = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk_i);
        checkOutput("rst_m_valid", m_valid_o, 1'b0);
        checkOutput("rst_m_sof_eol", {m_sof_o, m_eol_o}, 2'b00);
        checkOutput("rst_m_data", m_data_o, '0);
        checkOutput("rst_s_ready", s_ready_o, 1'b0);
        checkOutput("rst_err", err_o, 2'b00);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("ready_after_rst", s_ready_o, 1'b1);

        // 12-beat line, beats 4..11 out, output one cycle after beat 4.
        $display("[TB] normal 12-beat line");
        readyMode = 0;
        alignDrive();
        sendLine(12, 12, 4, 11, -1, 4);
        waitDrain("t1");
        checkOutput("t1_err", err_o, 2'b00);

        // Same line under toggling / stalled downstream.
        $display("[TB] backpressure");
        readyMode = 1;
        alignDrive();
        fork
            sendLine(12, 12, 4, 11, -1, -1);
            begin
                repeat (9) @(negedge clk_i);
                readyMode = 2;
                repeat (6) @(negedge clk_i);
                checkOutput("t2_s_ready_low", s_ready_o, 1'b0);
                checkOutput("t2_buffered", expQ.size(), 2);
                checkOutput("t2_valid_held", m_valid_o, 1'b1);
                readyMode = 1;
            end
        join
        readyMode = 0;
        waitDrain("t2");

        // Short line then a normal 10-beat line.
        $display("[TB] short line");
        alignDrive();
        sendLine(3, 3, 99, -1, -1, -1);
        repeat (3) @(negedge clk_i);
        checkOutput("t3_err_short", err_o, 2'b01);
        checkOutput("t3_no_valid", m_valid_o, 1'b0);
        alignDrive();
        sendLine(10, 10, 4, 9, -1, -1);
        waitDrain("t3");
        checkOutput("t3_err_kept", err_o, 2'b01);
        clearErrors();

        // 20-beat line exceeds 8 beats: beats 4..11, eol forced on 11.
        $display("[TB] long line");
        alignDrive();
        sendLine(20, 20, 4, 11, -1, -1);
        waitDrain("t4");
        checkOutput("t4_err_long", err_o, 2'b10);
        alignDrive();
        sendLine(6, 6, 4, 5, -1, -1);
        waitDrain("t4_next");
        clearErrors();

        // Bypass line, cfg toggled off mid-line without effect.
        $display("[TB] bypass");
        cfg_bypass_i = 1'b1;
        alignDrive();
        sendLine(6, 6, 0, 5, 2, -1);
        checkOutput("t5_throughput", lastAcc - firstAcc, 5);
        waitDrain("t5_bypass");
        alignDrive();
        sendLine(6, 6, 4, 5, -1, -1);
        waitDrain("t5_normal");
        alignDrive();
        sendLine(8, 8, 4, 7, 3, -1);
        waitDrain("t5_toggle_on");
        alignDrive();
        sendLine(3, 3, 0, 2, -1, -1);
        waitDrain("t5_bypass2");
        cfg_bypass_i = 1'b0;
        checkOutput("t5_err", err_o, 2'b00);

        // Reset in the middle of a line with two beats buffered.
        $display("[TB] reset mid-line");
        readyMode = 2;
        alignDrive();
        sendLine(12, 6, 4, 11, -1, -1);
        repeat (2) @(negedge clk_i);
        checkOutput("t6_buffered", expQ.size(), 2);
        checkOutput("t6_valid_before", m_valid_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_async_valid", m_valid_o, 1'b0);
        checkOutput("t6_async_ready", s_ready_o, 1'b0);
        expQ.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        readyMode = 0;
        alignDrive();
        sendLine(12, 12, 4, 11, -1, -1);
        waitDrain("t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dwt_row_aligner.md
Name: dwt_row_aligner

Overview:
- Output framing stage placed after the row lifting chain in the 2-D 9/7 DWT.
- Per line, discards the first SkipCount pipeline warm-up beats and re-attaches the line's start-of-frame marker to the first beat it emits.
- Generalises the single-lane fixed skip of the current row DWT:
  - parametric skip depth and lane count;
  - run-time bypass mode;
  - registered skid output;
  - line-length checking with sticky error flags.

Parameters:
- DataWidth, 16, width of one coefficient.
- Channels, 1, number of parallel component lanes sharing one handshake; each lane carries {high, low}.
- SkipCount, 4, warm-up beats dropped at the start of every line in normal mode; must be 1..15.
- MaximumSideSize, 512, maximum line length in samples; maximum emitted beats per line = MaximumSideSize/2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- cfg_bypass_i  in  1  1 = pass all beats, no skipping.
- s_ready_o  out  1  upstream ready.
- s_valid_i  in  1  upstream valid.
- s_sof_i  in  1  start of frame, on a line's first beat.
- s_eol_i  in  1  end of line, on a line's last beat.
- s_data_i  in  Channels*2*DataWidth  lane k occupies bits [k*2*DataWidth +: 2*DataWidth], {high, low}.
- m_ready_i  in  1  downstream ready.
- m_valid_o  out  1  downstream valid.
- m_sof_o  out  1  start of frame, on the first emitted beat.
- m_eol_o  out  1  end of line.
- m_data_o  out  Channels*2*DataWidth  same packing as s_data_i.
- err_o  out  2  sticky flags: [0] short line, [1] long line.
- err_clr_i  in  1  synchronous clear of err_o.

Behaviour:
- Reset (rst_ni low, async):
  - m_valid_o, m_sof_o, m_eol_o, err_o = 0; m_data_o = 0; s_ready_o = 0.
  - FSM enters SKIP; skip and beat counters = 0; pending_sof = 0; bypass latch = 0.
  - First cycle after deassertion: s_ready_o = 1.
- Handshake:
  - A transfer happens when valid && ready on that side.
  - m_valid_o, m_data_o, m_sof_o and m_eol_o are held stable while m_valid_o && !m_ready_i.
- Output stage: 2-entry skid buffer.
  - s_ready_o is a register; it is high whenever the buffer has at least one free entry.
  - Latency: accepted PASS beat -> m_valid_o on the next cycle.
  - Full throughput: 1 beat per clock when m_ready_i is held high.
- Bypass latch: cfg_bypass_i is sampled only when in SKIP with skip_cnt == 0. A change mid-line has no effect until the next line. With bypass set, the effective skip depth is 0.
- SKIP state:
  - Accepted beats are consumed and not written to the buffer; skip_cnt increments.
  - A beat with s_sof_i sets pending_sof.
  - skip_cnt reaching the effective skip depth -> PASS.
  - s_eol_i on a skipped beat: err_o[0] <= 1; the line produces no output; pending_sof cleared; skip_cnt <= 0; stay in SKIP.
- PASS state:
  - Accepted beats are written to the buffer.
  - Emitted m_sof_o = pending_sof | s_sof_i for the first PASS beat of a line, 0 for later beats; pending_sof clears when the first beat is written.
  - beat_cnt increments; width $clog2(MaximumSideSize/2+1).
  - s_eol_i: beat emitted with m_eol_o = 1; beat_cnt <= 0; skip_cnt <= 0 -> SKIP.
  - beat_cnt reaching MaximumSideSize/2 - 1 without s_eol_i: that beat is emitted with m_eol_o forced to 1; err_o[1] <= 1 -> DROP.
- DROP state:
  - Accepts and discards beats, with s_ready_o = 1 regardless of the buffer.
  - Exits to SKIP (counters 0) after accepting a beat with s_eol_i.
- err_clr_i: clears err_o. A new error condition in the same cycle wins, so the bit stays 1.
- Data is never modified: lane ordering and bit content pass through unchanged.

Optional Feature:
- Macro DWT_ROW_ALIGN_STATS_EN.
- When defined, adds two outputs:
  - stat_lines_o, 16-bit: count of lines emitted with m_eol_o; wraps at 2^16.
  - stat_skipped_o, 16-bit: count of beats consumed in SKIP or DROP; saturates at 16'hFFFF.
  - Both reset to 0 and clear together with err_clr_i.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Channels=1, SkipCount=4, 12-beat line with sof on beat 0, data = beat index, m_ready_i=1:
  - emits beats 4..11 (8 beats);
  - first emitted beat data 4 with m_sof_o=1; last with m_eol_o=1;
  - first output 1 cycle after beat 4 is accepted.
- Same line with m_ready_i toggling 1010..., then held low for 5 cycles: no loss or duplication; outputs stable while stalled; s_ready_o drops after 2 buffered beats.
- 3-beat line ending in eol (SkipCount=4): no m_valid_o; err_o=2'b01; the following 10-beat line emits 6 beats normally.
- MaximumSideSize=16, 20-beat line:
  - 8 beats emitted, the 8th with m_eol_o=1; err_o=2'b10;
  - remaining 8 beats dropped; next line starts in SKIP.
- cfg_bypass_i=1 at the line boundary, Channels=3: all 6 beats pass with sof and eol intact; toggling cfg_bypass_i mid-line changes nothing until the next line.
- Assert rst_ni low mid-line with 2 beats buffered: m_valid_o=0 immediately; after release the next line is processed from SKIP with skip_cnt 0.
